// File: rtl/ubutterfly_stream_decoder.sv
// ubutterfly_stream_decoder
// Turns the four unary bitstreams of a butterfly stage (real0, img0, real1,
// img1) back into binary. Each stream's ones are counted over a window of
// 2^BITWIDTH enabled samples. The four counts are then held on a valid/ready
// result interface until the consumer takes them.
module ubutterfly_stream_decoder #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned CNTW     = BITWIDTH + 1
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iStart,
  input  logic            iClr,
  input  logic            iEn,
  input  logic            iReal0,
  input  logic            iImg0,
  input  logic            iReal1,
  input  logic            iImg1,
  input  logic            iReady,
  output logic            oBusy,
  output logic            oValid,
  output logic [CNTW-1:0] oCntReal0,
  output logic [CNTW-1:0] oCntImg0,
  output logic [CNTW-1:0] oCntReal1,
  output logic [CNTW-1:0] oCntImg1
);

  localparam int unsigned NSTREAM = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [BITWIDTH-1:0] smp_q, smp_d;
  logic [CNTW-1:0]     acc_q [NSTREAM];
  logic [CNTW-1:0]     acc_d [NSTREAM];
  logic [CNTW-1:0]     res_q [NSTREAM];
  logic [CNTW-1:0]     res_d [NSTREAM];

  logic [NSTREAM-1:0]  bits_c;
  logic                sample_c;
  logic                last_c;
  logic                enter_run_c;

  // Stream bits gathered in result-lane order: 0=real0 1=img0 2=real1 3=img1
  assign bits_c = {iImg1, iReal1, iImg0, iReal0};

  // A sample is taken only in RUN with iEn high; iClr wins over sampling
  assign sample_c = (state_q == S_RUN) && iEn && !iClr;

  // The sample counter at all-ones marks the Nth sample of the window
  assign last_c = sample_c && (&smp_q);

  // Any transition into RUN (from IDLE or straight from HOLD) starts a new window
  assign enter_run_c = (state_d == S_RUN) && (state_q != S_RUN);

  // State register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; iClr overrides start and handshake
  always_comb begin
    state_d = state_q;
    if (iClr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (last_c) begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (iReady) begin
            state_d = iStart ? S_RUN : S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they register with it
  always_comb begin
    busy_d  = 1'b0;
    valid_d = 1'b0;
    case (state_d)
      S_RUN:   busy_d  = 1'b1;
      S_HOLD:  valid_d = 1'b1;
      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Window datapath: clear on abort or window start, accumulate on samples,
  // and capture the final sums (including the Nth bit) into the result regs
  always_comb begin
    smp_d = smp_q;
    for (int unsigned k = 0; k < NSTREAM; k++) begin
      acc_d[k] = acc_q[k];
      res_d[k] = res_q[k];
    end
    if (iClr || enter_run_c) begin
      smp_d = '0;
      for (int unsigned k = 0; k < NSTREAM; k++) begin
        acc_d[k] = '0;
      end
    end else if (sample_c) begin
      smp_d = smp_q + BITWIDTH'(1);
      for (int unsigned k = 0; k < NSTREAM; k++) begin
        acc_d[k] = acc_q[k] + CNTW'(bits_c[k]);
        if (last_c) begin
          res_d[k] = acc_q[k] + CNTW'(bits_c[k]);
        end
      end
    end
  end

  // Datapath and status registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      smp_q   <= '0;
      for (int unsigned k = 0; k < NSTREAM; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      smp_q   <= smp_d;
      for (int unsigned k = 0; k < NSTREAM; k++) begin
        acc_q[k] <= acc_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign oBusy     = busy_q;
  assign oValid    = valid_q;
  assign oCntReal0 = res_q[0];
  assign oCntImg0  = res_q[1];
  assign oCntReal1 = res_q[2];
  assign oCntImg1  = res_q[3];

endmodule

// File: tb/tb_ubutterfly_stream_decoder.sv
// Bench for ubutterfly_stream_decoder: directed scenarios plus randomized
// windows, checked every cycle against a transaction-level model.
module tb_ubutterfly_stream_decoder;

  localparam int BW = 8;
  localparam int CW = BW + 1;
  localparam int N  = 1 << BW;

  logic          iClk = 1'b0;
  logic          iRst, iStart, iClr, iEn, iReady;
  logic          iReal0, iImg0, iReal1, iImg1;
  logic          oBusy, oValid;
  logic [CW-1:0] oCntReal0, oCntImg0, oCntReal1, oCntImg1;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  ubutterfly_stream_decoder #(.BITWIDTH(BW)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iClr(iClr), .iEn(iEn),
    .iReal0(iReal0), .iImg0(iImg0), .iReal1(iReal1), .iImg1(iImg1),
    .iReady(iReady), .oBusy(oBusy), .oValid(oValid),
    .oCntReal0(oCntReal0), .oCntImg0(oCntImg0),
    .oCntReal1(oCntReal1), .oCntImg1(oCntImg1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int dut_cnt(input int k);
    case (k)
      0:       return int'(oCntReal0);
      1:       return int'(oCntImg0);
      2:       return int'(oCntReal1);
      default: return int'(oCntImg1);
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  bit m_run, m_hold;
  int m_sum[4];
  int m_n;
  int m_res[4];
  logic [3:0] m_bits;
  assign m_bits = {iImg1, iReal1, iImg0, iReal0};

  task automatic m_new_window();
    m_run = 1'b1;
    m_n   = 0;
    for (int k = 0; k < 4; k++) m_sum[k] = 0;
  endtask

  initial begin
    forever begin
      @(posedge iClk or posedge iRst);
      if (iRst) begin
        m_run = 1'b0; m_hold = 1'b0; m_n = 0;
        for (int k = 0; k < 4; k++) begin m_sum[k] = 0; m_res[k] = 0; end
      end else if (iClr) begin
        m_run = 1'b0; m_hold = 1'b0;
      end else if (m_run) begin
        if (iEn) begin
          for (int k = 0; k < 4; k++) m_sum[k] += int'(m_bits[k]);
          m_n++;
          if (m_n == N) begin
            for (int k = 0; k < 4; k++) m_res[k] = m_sum[k];
            m_run = 1'b0; m_hold = 1'b1;
          end
        end
      end else if (m_hold) begin
        if (iReady) begin
          m_hold = 1'b0;
          if (iStart) m_new_window();
        end
      end else if (iStart) begin
        m_new_window();
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge iClk);
      check("busy",  int'(oBusy),  int'(m_run));
      check("valid", int'(oValid), int'(m_hold));
      for (int k = 0; k < 4; k++) check($sformatf("cnt%0d", k), dut_cnt(k), m_res[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_bits(input logic [3:0] v);
    {iImg1, iReal1, iImg0, iReal0} = v;
  endtask

  task automatic start_pulse();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic handshake();
    iEn = 1'b0; iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check("hs_valid_low", int'(oValid), 0);
  endtask

  task automatic check_counts(input string name, input int c0, input int c1,
                              input int c2, input int c3);
    check({name, "_r0"}, int'(oCntReal0), c0);
    check({name, "_i0"}, int'(oCntImg0),  c1);
    check({name, "_r1"}, int'(oCntReal1), c2);
    check({name, "_i1"}, int'(oCntImg1),  c3);
  endtask

  initial begin
    int cyc;
    iRst = 1'b1; iStart = 1'b0; iClr = 1'b0; iEn = 1'b0; iReady = 1'b0;
    set_bits(4'h0);
    repeat (3) tick();
    check("rst_busy", int'(oBusy), 0);
    check("rst_valid", int'(oValid), 0);
    check_counts("rst", 0, 0, 0, 0);
    iRst = 1'b0;
    tick();

    // All ones, iEn constant: valid exactly after the 256th sample
    start_pulse();
    check("t1_busy", int'(oBusy), 1);
    iEn = 1'b1; set_bits(4'hF);
    for (int i = 1; i <= N; i++) begin
      tick();
      if (i == N - 1) check("t1_lat_early", int'(oValid), 0);
      if (i == N)     check("t1_lat_n", int'(oValid), 1);
    end
    check_counts("t1", 256, 256, 256, 256);
    handshake();

    // iEn toggling: bits high during disabled cycles are not counted
    start_pulse();
    set_bits(4'hF);
    for (int i = 0; i < 2 * N; i++) begin
      iEn = (i % 2 == 0);
      tick();
      if (i == 2 * N - 3) check("t3_early", int'(oValid), 0);
    end
    check("t3_valid", int'(oValid), 1);
    check_counts("t3", 256, 256, 256, 256);
    handshake();

    // Patterned streams: 0, all, alternating, one-in-four
    start_pulse();
    iEn = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_bits({(i % 4 == 0), (i % 2 == 0), 1'b1, 1'b0});
      tick();
    end
    check("t2_valid", int'(oValid), 1);
    check_counts("t2", 0, 256, 128, 64);

    // Hold with no ready: stable for 20 cycles, stream activity ignored
    for (int i = 0; i < 20; i++) begin
      iEn = 1'($urandom); set_bits(4'($urandom));
      tick();
      check("t4_hold_valid", int'(oValid), 1);
      check_counts("t4_hold", 0, 256, 128, 64);
    end
    // Handshake with start: straight back into RUN
    iReady = 1'b1; iStart = 1'b1;
    tick();
    iReady = 1'b0; iStart = 1'b0;
    check("t4_b2b_busy", int'(oBusy), 1);
    check("t4_b2b_valid", int'(oValid), 0);

    // Abort at sample 100; iClr beats a simultaneous iStart
    iEn = 1'b1;
    for (int i = 0; i < 100; i++) begin set_bits(4'($urandom)); tick(); end
    iClr = 1'b1; iStart = 1'b1;
    tick();
    iClr = 1'b0; iStart = 1'b0;
    check("t5_busy", int'(oBusy), 0);
    check("t5_valid", int'(oValid), 0);
    check_counts("t5_keep", 0, 256, 128, 64);
    start_pulse();
    set_bits(4'hF); iEn = 1'b1;
    repeat (N) tick();
    check("t5_valid2", int'(oValid), 1);
    check_counts("t5_full", 256, 256, 256, 256);
    handshake();

    // Asynchronous reset mid-RUN, between clock edges
    start_pulse();
    iEn = 1'b1; set_bits(4'hF);
    repeat (50) tick();
    #3 iRst = 1'b1;
    #1;
    check("t6_busy", int'(oBusy), 0);
    check("t6_valid", int'(oValid), 0);
    check_counts("t6", 0, 0, 0, 0);
    #2 iRst = 1'b0;
    repeat (5) tick();
    check("t6_idle_busy", int'(oBusy), 0);
    check("t6_idle_valid", int'(oValid), 0);

    // Randomized windows: sparse iEn, stray starts, random ready
    for (int w = 0; w < 6; w++) begin
      start_pulse();
      cyc = 0;
      while (!oValid && cyc < 3000) begin
        iEn = ($urandom_range(3) != 0);
        set_bits(4'($urandom));
        iStart = ($urandom_range(15) == 0);
        tick();
        cyc++;
      end
      iStart = 1'b0;
      check("rnd_window_timeout", int'(cyc < 3000), 1);
      cyc = 0;
      while (oValid && cyc < 200) begin
        iEn = 1'($urandom); set_bits(4'($urandom));
        iReady = ($urandom_range(3) == 0);
        iStart = 1'($urandom);
        tick();
        cyc++;
      end
      iReady = 1'b0; iStart = 1'b0;
      check("rnd_hold_timeout", int'(cyc < 200), 1);
    end
    // Drain any back-to-back window left running
    iEn = 1'b1;
    cyc = 0;
    while (!oValid && oBusy && cyc < 1000) begin tick(); cyc++; end
    iEn = 1'b0; iReady = 1'b1;
    repeat (3) tick();
    iReady = 1'b0;
    check("end_idle", int'(oBusy | oValid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
